channel_impairment: RTL and testbench
=====================================

# channel_impairment

Synthesizable, parametrised channel model that sits between the convolutional encoder and the Viterbi decoder. It replaces the hard-wired periodic error injection with a run-time configurable injector. The injector supports pass-through, periodic, burst and pseudo-random modes, a per-bit error mask, and a measurement window. It adds one registered pipeline stage and keeps saturating symbol and bit-error counters, so the bench and a future on-chip BER monitor can read the actual injected error rate.

## Interface
Parameters:
- W, 2, symbol width in bits (code rate 1/W encoder output)
- CNT_W, 16, width of the symbol and bit-error counters and of the window
- SEED, 16'hACE1, LFSR reload value; must be nonzero

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- cfg_mode_i  in  2  0 PASS, 1 PERIODIC, 2 BURST, 3 RANDOM
- cfg_period_i  in  8  symbols per injection period; 0 treated as 1
- cfg_burst_len_i  in  8  consecutive corrupted symbols per burst in BURST mode
- cfg_thresh_i  in  16  RANDOM mode: inject when lfsr < thresh
- cfg_mask_i  in  W  bits flipped on an injected symbol
- cfg_window_i  in  CNT_W  number of symbols eligible for injection; 0 means unlimited
- clr_i  in  1  synchronous clear of counters, FSM and LFSR
- valid_i  in  1  sym_i valid this cycle
- sym_i  in  W  encoder output symbol
- valid_o  out  1  registered copy of valid_i
- sym_o  out  W  possibly corrupted symbol
- err_o  out  1  1 when sym_o carries injected errors
- sym_ct_o  out  CNT_W  valid symbols seen (saturating)
- bit_err_ct_o  out  CNT_W  total flipped bits (saturating)
- done_o  out  1  window exhausted (sticky)

## Operation
- Reset (rst low): valid_o=0, sym_o=0, err_o=0, sym_ct_o=0, bit_err_ct_o=0, done_o=0. Also: FSM=COUNT, period counter pcnt=0, burst counter bcnt=0, LFSR=SEED.
- The block advances only on cycles with valid_i=1; with valid_i=0 all state holds.
- Injecting a symbol means sym_o = sym_i ^ cfg_mask_i and err_o=1. Otherwise sym_o = sym_i and err_o=0.
- On each injected symbol, bit_err_ct_o increments by popcount(cfg_mask_i). Each counter saturates at 2^CNT_W-1.
- sym_ct_o increments on every valid symbol, including symbols after done.
- Eligibility: a symbol is eligible when cfg_window_i==0 or sym_ct_o < cfg_window_i, with sym_ct_o sampled before the increment. A non-eligible symbol passes clean, and done_o is set and stays set until clr_i or reset.
- FSM states are COUNT, BURST and DONE. Entry to DONE happens on the first non-eligible symbol, from any state.
- PASS: never inject. pcnt and the LFSR hold.
- PERIODIC, state COUNT: inject when pcnt==P-1, where P=max(cfg_period_i,1). pcnt then wraps to 0; otherwise pcnt increments.
- BURST, state COUNT: when pcnt==P-1, inject, go to BURST with bcnt=1, and set pcnt=0. If cfg_burst_len_i==1, stay in COUNT instead.
- BURST, state BURST: inject and increment bcnt. When bcnt reaches cfg_burst_len_i, return to COUNT. pcnt stays at 0 during the burst.
- BURST with cfg_burst_len_i==0: never inject, but pcnt still runs.
- RANDOM: the LFSR steps once per valid symbol. Inject when the pre-step LFSR value < cfg_thresh_i.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
- Mode change while in BURST: return to COUNT at the next valid symbol, with no injection on that symbol unless the new mode injects.
- clr_i=1: counters, pcnt and bcnt go to 0, LFSR goes to SEED, FSM goes to COUNT, and done_o clears. clr_i takes priority over a simultaneous valid_i: that symbol is forwarded clean, is not counted, and does not advance the FSM.

## Timing
- Latency 1 cycle: valid_i, sym_i at edge k appear as valid_o, sym_o, err_o after edge k+1.
- Counter outputs update on the same edge as the corresponding sym_o.
- No backpressure. Back-to-back valid symbols are accepted every cycle.
- Configuration inputs are sampled on every valid cycle and must be quasi-static within a measurement.

## Structure
- Package chan_imp_pkg contains:
  - the mode enum (PASS, PERIODIC, BURST, RANDOM)
  - the FSM state enum (COUNT, BURST, DONE)
  - the LFSR tap constant and the default SEED
  - a popcount function over W bits
- Sub-module chan_lfsr16 contains the LFSR register with step, load-seed and value-out.
- The top level holds the FSM, counters and output register.

## Test plan
- PERIODIC, P=4, mask=2'b11, window=0, 16 valid symbols: err_o is 1 on symbols 3, 7, 11, 15. Final bit_err_ct_o=8, sym_ct_o=16, done_o=0.
- BURST, P=8, L=3, mask=2'b01, 24 symbols: symbols 7, 8, 9, 17, 18, 19 are corrupted in bit 0 only. Final bit_err_ct_o=6.
- RANDOM, thresh=0, then thresh=16'hFFFF, 1000 symbols each after clr_i: 0 errors for thresh=0; 1000 or 999 errors for thresh=16'hFFFF (only LFSR==FFFF escapes). The sequence matches the package reference LFSR model.
- Window=256, PERIODIC P=16, mask=2'b10, 300 symbols: 16 injections, done_o rises at the output of symbol 256, symbols 256–299 are clean, sym_ct_o=300.
- Reset asserted mid-burst, then released: all outputs 0, FSM=COUNT, pcnt=0. The next burst starts after P symbols. clr_i together with valid_i: that symbol is clean and not counted.
- Saturation with CNT_W=4, mask=2'b11, P=1, 20 symbols: bit_err_ct_o and sym_ct_o hold at 15.

Source files
------------

// File: rtl/chan_imp_pkg.sv
// Shared types and helpers for the channel impairment injector.
// Mode and FSM encodings, LFSR constants and a bit counter.
package chan_imp_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_RANDOM   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Right-shifting form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Masks up to this width are supported by popcount.
  localparam int POP_MAX_W = 32;

  function automatic logic [7:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// 16-bit Fibonacci LFSR with seed reload and enable-gated stepping.
// Reset and load both return the register to SEED.
module chan_lfsr16
  import chan_imp_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/channel_impairment.sv
// Configurable error injector between convolutional encoder and Viterbi decoder.
// One register stage; saturating symbol and bit-error counters; windowed injection.
module channel_impairment
  import chan_imp_pkg::*;
#(
  parameter int          W     = 2,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode_i,
  input  logic [7:0]       cfg_period_i,
  input  logic [7:0]       cfg_burst_len_i,
  input  logic [15:0]      cfg_thresh_i,
  input  logic [W-1:0]     cfg_mask_i,
  input  logic [CNT_W-1:0] cfg_window_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [W-1:0]     sym_i,
  output logic             valid_o,
  output logic [W-1:0]     sym_o,
  output logic             err_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] bit_err_ct_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W+7:0] SUM_MAX = {8'd0, CNT_MAX};

  mode_e       mode;
  state_e      state, state_next;
  logic [7:0]  pcnt, pcnt_next, bcnt, bcnt_next, bcnt_inc, last;
  logic [15:0] lfsr;
  logic        eligible, hit, inject, lfsr_step;
  logic [7:0]  pop;
  logic [CNT_W+7:0] err_sum;

  assign mode     = mode_e'(cfg_mode_i);
  assign last     = (cfg_period_i == 8'd0) ? 8'd0 : cfg_period_i - 8'd1;
  // >= rather than == so a shrinking period cannot strand pcnt above the wrap point
  assign hit      = (pcnt >= last);
  assign bcnt_inc = bcnt + 8'd1;
  assign eligible = (cfg_window_i == '0) || (sym_ct_o < cfg_window_i);
  assign pop      = popcount(POP_MAX_W'(cfg_mask_i));
  assign err_sum  = {8'd0, bit_err_ct_o} + {{CNT_W{1'b0}}, pop};

  chan_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (clr_i),
    .step  (lfsr_step),
    .value (lfsr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_COUNT;
      pcnt  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_next;
      pcnt  <= pcnt_next;
      bcnt  <= bcnt_next;
    end
  end

  // A BURST state seen under a non-burst mode is handled as COUNT.
  always_comb begin
    state_next = state;
    pcnt_next  = pcnt;
    bcnt_next  = bcnt;
    if (clr_i) begin
      state_next = ST_COUNT;
      pcnt_next  = '0;
      bcnt_next  = '0;
    end else if (valid_i) begin
      if (!eligible) begin
        state_next = ST_DONE;
      end else if (state != ST_DONE) begin
        case (mode)
          MODE_PERIODIC: begin
            state_next = ST_COUNT;
            bcnt_next  = '0;
            pcnt_next  = hit ? 8'd0 : pcnt + 8'd1;
          end
          MODE_BURST: begin
            if (state == ST_BURST) begin
              bcnt_next = bcnt_inc;
              if (bcnt_inc >= cfg_burst_len_i) begin
                state_next = ST_COUNT;
                bcnt_next  = '0;
              end
            end else if (hit) begin
              pcnt_next = '0;
              if (cfg_burst_len_i > 8'd1) begin
                state_next = ST_BURST;
                bcnt_next  = 8'd1;
              end
            end else begin
              pcnt_next = pcnt + 8'd1;
            end
          end
          default: begin
            state_next = ST_COUNT;
            bcnt_next  = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    inject    = 1'b0;
    lfsr_step = 1'b0;
    if (valid_i && !clr_i) begin
      lfsr_step = (mode == MODE_RANDOM);
      if (eligible && state != ST_DONE) begin
        case (mode)
          MODE_PERIODIC: inject = hit;
          MODE_BURST:    inject = (state == ST_BURST) || (hit && cfg_burst_len_i != 8'd0);
          MODE_RANDOM:   inject = (lfsr < cfg_thresh_i);
          default:       inject = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o      <= 1'b0;
      sym_o        <= '0;
      err_o        <= 1'b0;
      sym_ct_o     <= '0;
      bit_err_ct_o <= '0;
      done_o       <= 1'b0;
    end else begin
      valid_o <= valid_i;
      sym_o   <= inject ? (sym_i ^ cfg_mask_i) : sym_i;
      err_o   <= inject;
      if (clr_i) begin
        sym_ct_o     <= '0;
        bit_err_ct_o <= '0;
        done_o       <= 1'b0;
      end else if (valid_i) begin
        if (sym_ct_o != CNT_MAX) begin
          sym_ct_o <= sym_ct_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (inject) begin
          bit_err_ct_o <= (err_sum > SUM_MAX) ? CNT_MAX : err_sum[CNT_W-1:0];
        end
        if (!eligible) begin
          done_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_impairment.sv
// Directed bench for channel_impairment: a vector table plus multi-cycle sequences.
// A second instance with 4-bit counters exercises saturation.
module tb_channel_impairment;

  logic        clk;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_period;
  logic [7:0]  cfg_burst_len;
  logic [15:0] cfg_thresh;
  logic [1:0]  cfg_mask;
  logic [15:0] cfg_window;
  logic        clr;
  logic        valid;
  logic [1:0]  sym;

  logic        valid_o, err_o, done_o;
  logic [1:0]  sym_o;
  logic [15:0] sym_ct, bit_err_ct;

  logic        s_valid_o, s_err_o, s_done_o;
  logic [1:0]  s_sym_o;
  logic [3:0]  s_sym_ct, s_bit_err_ct;

  int checks = 0;
  int errors = 0;

  channel_impairment #(.W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_mode_i(cfg_mode), .cfg_period_i(cfg_period),
    .cfg_burst_len_i(cfg_burst_len), .cfg_thresh_i(cfg_thresh), .cfg_mask_i(cfg_mask),
    .cfg_window_i(cfg_window), .clr_i(clr), .valid_i(valid), .sym_i(sym),
    .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o), .sym_ct_o(sym_ct),
    .bit_err_ct_o(bit_err_ct), .done_o(done_o)
  );

  channel_impairment #(.W(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .cfg_mode_i(cfg_mode), .cfg_period_i(cfg_period),
    .cfg_burst_len_i(cfg_burst_len), .cfg_thresh_i(cfg_thresh), .cfg_mask_i(cfg_mask),
    .cfg_window_i(4'd0), .clr_i(clr), .valid_i(valid), .sym_i(sym),
    .valid_o(s_valid_o), .sym_o(s_sym_o), .err_o(s_err_o), .sym_ct_o(s_sym_ct),
    .bit_err_ct_o(s_bit_err_ct), .done_o(s_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  period;
    logic [7:0]  blen;
    logic [1:0]  mask;
    logic        vclr;
    logic        vvalid;
    logic [1:0]  vsym;
    logic        ev;
    logic [1:0]  es;
    logic        ee;
    logic [15:0] ect;
    logic [15:0] ebe;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] s);
    valid = 1'b1;
    sym   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    valid = 1'b0;
    clr   = 1'b1;
    @(posedge clk);
    #1;
    clr   = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [7:0] p, input logic [7:0] l,
                         input logic [1:0] mk, input logic [15:0] th, input logic [15:0] win);
    cfg_mode = m; cfg_period = p; cfg_burst_len = l; cfg_mask = mk;
    cfg_thresh = th; cfg_window = win;
  endtask

  function automatic logic [15:0] tb_lfsr(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  initial begin
    int ecnt, ecnt2, esc;
    logic [15:0] m;
    logic exp_e;
    logic [1:0] exp_s;

    rst = 1'b0; clr = 1'b0; valid = 1'b0; sym = '0;
    set_cfg(2'd0, 8'd0, 8'd0, 2'd0, 16'd0, 16'd0);

    // reset state
    #12;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_sym_o", sym_o, 0);
    chk("rst_err_o", err_o, 0);
    chk("rst_sym_ct", sym_ct, 0);
    chk("rst_bit_err_ct", bit_err_ct, 0);
    chk("rst_done", done_o, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // vector table: {mode, P, L, mask, clr, valid, sym} -> {valid_o, sym_o, err_o, sym_ct, bit_err}
    tbl[0]  = '{2'd0, 8'd3, 8'd0, 2'd3, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 16'd1, 16'd0};
    tbl[1]  = '{2'd1, 8'd3, 8'd0, 2'd1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 16'd2, 16'd0};
    tbl[2]  = '{2'd1, 8'd3, 8'd0, 2'd1, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 16'd2, 16'd0};
    tbl[3]  = '{2'd1, 8'd3, 8'd0, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 16'd3, 16'd0};
    tbl[4]  = '{2'd1, 8'd3, 8'd0, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 16'd4, 16'd1};
    tbl[5]  = '{2'd1, 8'd0, 8'd0, 2'd1, 1'b0, 1'b1, 2'd3, 1'b1, 2'd2, 1'b1, 16'd5, 16'd2};
    tbl[6]  = '{2'd2, 8'd2, 8'd2, 2'd2, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 16'd6, 16'd2};
    tbl[7]  = '{2'd2, 8'd2, 8'd2, 2'd2, 1'b0, 1'b1, 2'd0, 1'b1, 2'd2, 1'b1, 16'd7, 16'd3};
    tbl[8]  = '{2'd2, 8'd2, 8'd2, 2'd2, 1'b0, 1'b1, 2'd1, 1'b1, 2'd3, 1'b1, 16'd8, 16'd4};
    tbl[9]  = '{2'd2, 8'd2, 8'd2, 2'd2, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 16'd9, 16'd4};
    tbl[10] = '{2'd2, 8'd2, 8'd2, 2'd2, 1'b1, 1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 16'd0, 16'd0};
    tbl[11] = '{2'd2, 8'd1, 8'd0, 2'd3, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 16'd1, 16'd0};
    tbl[12] = '{2'd2, 8'd1, 8'd1, 2'd3, 1'b0, 1'b1, 2'd2, 1'b1, 2'd1, 1'b1, 16'd2, 16'd2};
    tbl[13] = '{2'd2, 8'd1, 8'd1, 2'd3, 1'b0, 1'b1, 2'd2, 1'b1, 2'd1, 1'b1, 16'd3, 16'd4};
    tbl[14] = '{2'd0, 8'd1, 8'd1, 2'd3, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 16'd4, 16'd4};
    tbl[15] = '{2'd2, 8'd1, 8'd4, 2'd1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 16'd5, 16'd5};
    tbl[16] = '{2'd1, 8'd2, 8'd4, 2'd1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 16'd6, 16'd5};
    tbl[17] = '{2'd1, 8'd2, 8'd4, 2'd1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 16'd7, 16'd6};

    do_clr();
    for (int i = 0; i < 18; i++) begin
      set_cfg(tbl[i].mode, tbl[i].period, tbl[i].blen, tbl[i].mask, 16'd0, 16'd0);
      clr = tbl[i].vclr; valid = tbl[i].vvalid; sym = tbl[i].vsym;
      @(posedge clk); #1;
      clr = 1'b0;
      $display("vec %0d: mode=%0d valid_o=%0b sym_o=%0d err_o=%0b sym_ct=%0d bit_err=%0d",
               i, tbl[i].mode, valid_o, sym_o, err_o, sym_ct, bit_err_ct);
      chk($sformatf("vec%0d_valid_o", i), valid_o, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("vec%0d_sym_o", i), sym_o, tbl[i].es);
      chk($sformatf("vec%0d_err_o", i), err_o, tbl[i].ee);
      chk($sformatf("vec%0d_sym_ct", i), sym_ct, tbl[i].ect);
      chk($sformatf("vec%0d_bit_err", i), bit_err_ct, tbl[i].ebe);
      chk($sformatf("vec%0d_done", i), done_o, 0);
    end

    // periodic P=4, mask 11
    do_clr();
    set_cfg(2'd1, 8'd4, 8'd0, 2'd3, 16'd0, 16'd0);
    for (int i = 0; i < 16; i++) begin
      send(2'(i));
      exp_e = (i % 4 == 3);
      exp_s = exp_e ? (2'(i) ^ 2'd3) : 2'(i);
      chk($sformatf("per_err%0d", i), err_o, exp_e);
      chk($sformatf("per_sym%0d", i), sym_o, exp_s);
    end
    $display("periodic: sym_ct=%0d bit_err=%0d done=%0b", sym_ct, bit_err_ct, done_o);
    chk("per_bit_err", bit_err_ct, 8);
    chk("per_sym_ct", sym_ct, 16);
    chk("per_done", done_o, 0);

    // burst P=8, L=3, mask 01
    do_clr();
    set_cfg(2'd2, 8'd8, 8'd3, 2'd1, 16'd0, 16'd0);
    for (int i = 0; i < 24; i++) begin
      send(2'(i));
      exp_e = (i >= 7 && i <= 9) || (i >= 17 && i <= 19);
      exp_s = exp_e ? (2'(i) ^ 2'd1) : 2'(i);
      chk($sformatf("bst_err%0d", i), err_o, exp_e);
      chk($sformatf("bst_sym%0d", i), sym_o, exp_s);
    end
    $display("burst: sym_ct=%0d bit_err=%0d", sym_ct, bit_err_ct);
    chk("bst_bit_err", bit_err_ct, 6);

    // random: thresh 0, thresh FFFF, thresh 8000 against reference LFSR
    do_clr();
    set_cfg(2'd3, 8'd0, 8'd0, 2'd3, 16'h0000, 16'd0);
    ecnt = 0;
    for (int i = 0; i < 1000; i++) begin
      send(2'(i));
      if (err_o) ecnt++;
    end
    $display("random thresh=0000: errors injected=%0d", ecnt);
    chk("rnd0_count", ecnt, 0);

    do_clr();
    set_cfg(2'd3, 8'd0, 8'd0, 2'd3, 16'hFFFF, 16'd0);
    ecnt = 0; esc = 0; m = 16'hACE1;
    for (int i = 0; i < 1000; i++) begin
      send(2'(i));
      if (err_o) ecnt++;
      if (m == 16'hFFFF) esc++;
      m = tb_lfsr(m);
    end
    $display("random thresh=FFFF: errors injected=%0d", ecnt);
    chk("rndF_count", ecnt, 1000 - esc);
    chk("rndF_range", (ecnt == 1000 || ecnt == 999), 1);
    chk("rndF_bit_err", bit_err_ct, 2 * ecnt);

    do_clr();
    set_cfg(2'd3, 8'd0, 8'd0, 2'd1, 16'h8000, 16'd0);
    m = 16'hACE1;
    for (int i = 0; i < 200; i++) begin
      send(2'd0);
      chk($sformatf("rnd8_err%0d", i), err_o, (m < 16'h8000));
      m = tb_lfsr(m);
    end
    $display("random thresh=8000: bit_err=%0d", bit_err_ct);

    // window 256, periodic P=16, mask 10
    do_clr();
    set_cfg(2'd1, 8'd16, 8'd0, 2'd2, 16'd0, 16'd256);
    ecnt = 0; ecnt2 = 0;
    for (int i = 0; i < 300; i++) begin
      send(2'(i));
      if (err_o && i < 256) ecnt++;
      if (err_o && i >= 256) ecnt2++;
      if (i == 255) chk("win_done_255", done_o, 0);
      if (i == 256) chk("win_done_256", done_o, 1);
    end
    $display("window: inj=%0d late=%0d sym_ct=%0d done=%0b", ecnt, ecnt2, sym_ct, done_o);
    chk("win_inj", ecnt, 16);
    chk("win_late", ecnt2, 0);
    chk("win_sym_ct", sym_ct, 300);
    chk("win_bit_err", bit_err_ct, 16);
    chk("win_done_end", done_o, 1);

    // reset asserted mid-burst
    do_clr();
    set_cfg(2'd2, 8'd4, 8'd3, 2'd3, 16'd0, 16'd0);
    for (int i = 0; i < 5; i++) send(2'd0);
    chk("mid_in_burst", err_o, 1);
    valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid_o", valid_o, 0);
    chk("mid_rst_err_o", err_o, 0);
    chk("mid_rst_sym_ct", sym_ct, 0);
    chk("mid_rst_bit_err", bit_err_ct, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(2'd0);
      chk($sformatf("post_rst_err%0d", i), err_o, (i == 3));
    end
    $display("post reset: sym_ct=%0d bit_err=%0d", sym_ct, bit_err_ct);
    chk("post_rst_sym_ct", sym_ct, 4);
    chk("post_rst_bit_err", bit_err_ct, 2);

    // clr together with valid
    set_cfg(2'd1, 8'd1, 8'd0, 2'd3, 16'd0, 16'd0);
    clr = 1'b1; valid = 1'b1; sym = 2'd1;
    @(posedge clk); #1;
    clr = 1'b0;
    $display("clr+valid: valid_o=%0b sym_o=%0d err_o=%0b sym_ct=%0d", valid_o, sym_o, err_o, sym_ct);
    chk("clrv_valid_o", valid_o, 1);
    chk("clrv_sym_o", sym_o, 1);
    chk("clrv_err_o", err_o, 0);
    chk("clrv_sym_ct", sym_ct, 0);
    chk("clrv_bit_err", bit_err_ct, 0);

    // saturation on the 4-bit instance
    do_clr();
    set_cfg(2'd1, 8'd1, 8'd0, 2'd3, 16'd0, 16'd0);
    for (int i = 0; i < 20; i++) begin
      send(2'd0);
      if (i == 6) chk("sat_bit_err_7", s_bit_err_ct, 14);
      if (i == 7) chk("sat_bit_err_8", s_bit_err_ct, 15);
    end
    $display("saturation: sym_ct=%0d bit_err=%0d", s_sym_ct, s_bit_err_ct);
    chk("sat_sym_ct", s_sym_ct, 15);
    chk("sat_bit_err", s_bit_err_ct, 15);
    chk("sat_done", s_done_o, 0);
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
